heart_beat_blink_coder: RTL and testbench
=========================================

// Module: heart_beat_blink_coder
// PURPOSE
// - Consumes heart_beat_o (a slowly toggling level) and uses each of its edges as a time-base tick.
// - Flashes a status code on one board LED as N blinks followed by a dark gap, then repeats.
// - Typical code sources: 10GE link state, PLL lock, error class.
// - Sits between heart_beat and the LED pin; gives a human-readable status without UART/JTAG.
// PARAMETERS
// - CODE_WIDTH  4  width of code_i; max blinks = 2**CODE_WIDTH-1
// - GAP_TICKS   4  dark ticks after last blink before next sequence; legal range >=1
// - PWM_WIDTH   4  width of brightness counter/duty; used only with HEART_BEAT_BLINK_PWM_EN
// PORTS
// - clk_i         in   1           system clock; same clock as the heart_beat instance
// - srst_i        in   1           synchronous reset, active-high
// - beat_i        in   1           heart_beat_o level; each edge (rise or fall) = 1 tick
// - code_i        in   CODE_WIDTH  blink count to display; 0 = LED dark
// - pwm_duty_i    in   PWM_WIDTH   LED brightness; port exists only with the macro
// - led_o         out  1           LED drive, registered
// - busy_o        out  1           1 while a sequence (blinks + gap) is in progress
// - seq_done_o    out  1           1-cycle pulse when a sequence's gap ends
// BEHAVIOUR
// - Interface: one clock clk_i; srst_i synchronous active-high. All outputs/state are registered.
// - Reset values:
//   - led_o=0, busy_o=0, seq_done_o=0.
//   - beat_q=0 (matches heart_beat reset level), state=IDLE, counters=0.
// - Tick detect:
//   - tick = beat_i ^ beat_q; beat_q <= beat_i every cycle.
//   - FSM advances only on clocks where tick=1.
//   - led_o changes on the same clock edge that samples the beat_i change (1-clk latency).
// - FSM states:
//   - IDLE: led=0, busy=0. Samples code_i every cycle.
//     - On tick with code_i!=0: latch code_i into cnt, go ON.
//     - code_i==0: stay IDLE.
//   - ON: led=1 for exactly 1 tick. Next tick -> OFF.
//   - OFF: led=0 for 1 tick. Next tick: cnt<=cnt-1.
//     - If cnt==1 -> GAP, loading gap_cnt=GAP_TICKS-1.
//     - Else -> ON.
//   - GAP: led=0. Each tick gap_cnt decrements.
//     - On tick with gap_cnt==0: seq_done_o=1 for that cycle.
//     - Then resample code_i: !=0 -> latch and go ON directly (no IDLE detour); ==0 -> IDLE.
// - busy_o=1 in ON/OFF/GAP.
// - Sequence timing: code N occupies 2N+GAP_TICKS ticks from the first ON tick to the seq_done tick.
// - Boundaries:
//   - code_i changes mid-sequence: ignored until next latch point (IDLE or end of GAP).
//   - code_i all-ones: 2**CODE_WIDTH-1 blinks; no wrap, cnt never underflows.
//   - GAP_TICKS=1: one dark tick; the gap counter must not wrap to all-ones.
//   - beat_i stuck (heart_beat held in reset): no ticks, state and led_o frozen.
//   - srst_i mid-sequence: next clock returns to reset values; no seq_done pulse.
// CONFIGURATION
// - HEART_BEAT_BLINK_PWM_EN defined:
//   - pwm_duty_i port present.
//   - Free-running PWM_WIDTH counter pwm_cnt, reset 0, increments every clk.
//   - led_o = led_on & (pwm_cnt < pwm_duty_i), registered.
//   - duty 0 -> LED always dark.
// - HEART_BEAT_BLINK_PWM_EN undefined:
//   - No port, no counter.
//   - led_o = led_on (full brightness).
//   - All other behaviour identical.
// TESTING
// - Reset: hold srst_i 3 clk, beat_i toggling -> led_o=0, busy_o=0, seq_done_o=0 throughout.
// - code_i=3, GAP_TICKS=4, beat_i toggling every 10 clk:
//   - led_o high for 3 windows of 10 clk, then 40 clk dark.
//   - seq_done_o pulses once at tick 10; sequence then repeats.
// - code_i=0 for 200 clk -> led_o=0, busy_o=0, no seq_done_o.
// - code_i=2 -> 5 after first blink:
//   - Current sequence shows 2 blinks.
//   - After seq_done_o, next sequence shows 5 blinks.
// - srst_i asserted during second ON of code 3 -> next clk led_o=0, busy_o=0; restart needs new tick.
// - PWM_EN, PWM_WIDTH=4, duty=8, code=1 -> during ON, led_o high 8 of every 16 clk; duty=0 -> never high.

Source files
------------

// File: rtl/heart_beat_blink_coder_if.sv
// Status-blinker signal bundle: heart-beat level and status code in; LED, busy and sequence-done out.
// The pwm_duty member exists only when HEART_BEAT_BLINK_PWM_EN is defined.
interface heart_beat_blink_coder_if #(
    parameter int CODE_WIDTH = 4,
    parameter int PWM_WIDTH  = 4
);
    logic                  beat;
    logic [CODE_WIDTH-1:0] code;
`ifdef HEART_BEAT_BLINK_PWM_EN
    logic [PWM_WIDTH-1:0]  pwm_duty;
`endif
    logic                  led;
    logic                  busy;
    logic                  seq_done;

`ifdef HEART_BEAT_BLINK_PWM_EN
    modport master (output beat, code, pwm_duty, input led, busy, seq_done);
    modport slave  (input beat, code, pwm_duty, output led, busy, seq_done);
`else
    modport master (output beat, code, input led, busy, seq_done);
    modport slave  (input beat, code, output led, busy, seq_done);
`endif
endinterface

// File: rtl/heart_beat_blink_coder.sv
// Flashes code N on an LED as N blinks plus a dark gap, one step per heart-beat edge.
// Optional brightness PWM is enabled by defining HEART_BEAT_BLINK_PWM_EN.
module heart_beat_blink_coder #(
    parameter int CODE_WIDTH = 4,
    parameter int GAP_TICKS  = 4,
    parameter int PWM_WIDTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    heart_beat_blink_coder_if.slave   bus
);
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    state_t                state_q, state_nxt;
    logic                  beat_q;
    logic [CODE_WIDTH-1:0] cnt_q, cnt_nxt;
    logic [GAP_W-1:0]      gap_q, gap_nxt;
    logic                  led_q, led_nxt;
    logic                  busy_q;
    logic                  done_q, done_nxt;
    logic                  tick;

    assign tick = bus.beat ^ beat_q;

`ifdef HEART_BEAT_BLINK_PWM_EN
    logic [PWM_WIDTH-1:0]  pwm_cnt_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) pwm_cnt_q <= '0;
        else        pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= S_IDLE;
            beat_q  <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            beat_q  <= bus.beat;
            cnt_q   <= cnt_nxt;
            gap_q   <= gap_nxt;
            led_q   <= led_nxt;
            busy_q  <= (state_nxt != S_IDLE);
            done_q  <= done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        gap_nxt   = gap_q;
        done_nxt  = 1'b0;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.code != '0) begin
                        cnt_nxt   = bus.code;
                        state_nxt = S_ON;
                    end
                end
                S_ON: state_nxt = S_OFF;
                S_OFF: begin
                    cnt_nxt = cnt_q - 1'b1;
                    if (cnt_q == CODE_WIDTH'(1)) begin
                        state_nxt = S_GAP;
                        gap_nxt   = GAP_W'(GAP_TICKS - 1);
                    end else begin
                        state_nxt = S_ON;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        // Sequence boundary: pulse done and latch the next code without an IDLE detour.
                        done_nxt = 1'b1;
                        if (bus.code != '0) begin
                            cnt_nxt   = bus.code;
                            state_nxt = S_ON;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        gap_nxt = gap_q - 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
`ifdef HEART_BEAT_BLINK_PWM_EN
        led_nxt = (state_nxt == S_ON) && (pwm_cnt_q < bus.pwm_duty);
`else
        led_nxt = (state_nxt == S_ON);
`endif
    end

    assign bus.led      = led_q;
    assign bus.busy     = busy_q;
    assign bus.seq_done = done_q;
endmodule

// File: tb/tb_heart_beat_blink_coder.sv
// Scoreboard bench for heart_beat_blink_coder: two DUTs (GAP_TICKS=4 and GAP_TICKS=1) share stimulus
// and are compared every cycle against a sequence-position model. Honours HEART_BEAT_BLINK_PWM_EN.
module tb_heart_beat_blink_coder;
    localparam int CW    = 4;
    localparam int PW    = 4;
    localparam int GAP_A = 4;
    localparam int GAP_B = 1;

    typedef struct {
        bit active;
        int n;
        int k;
    } model_t;

    typedef struct {
        bit led_a, busy_a, done_a;
        bit led_b, busy_b, done_b;
    } exp_t;

    logic   clk = 1'b0;
    logic   srst;
    exp_t   sb[$];
    model_t ma, mb;
    bit     beat_lvl;
    bit     beat_prev;
    int     checks = 0;
    int     errors = 0;
`ifdef HEART_BEAT_BLINK_PWM_EN
    int     duty = 15;
    int     pwm_val = 0;
`endif

    heart_beat_blink_coder_if #(.CODE_WIDTH(CW), .PWM_WIDTH(PW)) if_a ();
    heart_beat_blink_coder_if #(.CODE_WIDTH(CW), .PWM_WIDTH(PW)) if_b ();

    heart_beat_blink_coder #(.CODE_WIDTH(CW), .GAP_TICKS(GAP_A), .PWM_WIDTH(PW)) dut_a (
        .clk_i (clk),
        .srst_i(srst),
        .bus   (if_a.slave)
    );

    heart_beat_blink_coder #(.CODE_WIDTH(CW), .GAP_TICKS(GAP_B), .PWM_WIDTH(PW)) dut_b (
        .clk_i (clk),
        .srst_i(srst),
        .bus   (if_b.slave)
    );

    always #5 clk = ~clk;

    // A sequence for code N is 2N+gap windows: window k lit when k<2N and k even.
    function automatic void model_step(inout model_t m, input int gap, input bit tick,
                                       input int code, input bit rst,
                                       output bit led_on, output bit done);
        done = 1'b0;
        if (rst) begin
            m = '{active: 1'b0, n: 0, k: 0};
        end else if (tick) begin
            if (!m.active) begin
                if (code != 0) m = '{active: 1'b1, n: code, k: 0};
            end else begin
                m.k++;
                if (m.k == 2 * m.n + gap) begin
                    done = 1'b1;
                    if (code != 0) m = '{active: 1'b1, n: code, k: 0};
                    else           m.active = 1'b0;
                end
            end
        end
        led_on = m.active && (m.k < 2 * m.n) && (m.k % 2 == 0);
    endfunction

    task automatic cycle(input bit b, input int code, input bit rst);
        exp_t e;
        bit   tick;
        bit   on_a, on_b;
        if_a.beat = b;
        if_b.beat = b;
        if_a.code = CW'(code);
        if_b.code = CW'(code);
        srst      = rst;
        tick      = b ^ beat_prev;
        beat_prev = rst ? 1'b0 : b;
        model_step(ma, GAP_A, tick, code, rst, on_a, e.done_a);
        model_step(mb, GAP_B, tick, code, rst, on_b, e.done_b);
        e.busy_a = ma.active;
        e.busy_b = mb.active;
`ifdef HEART_BEAT_BLINK_PWM_EN
        if_a.pwm_duty = PW'(duty);
        if_b.pwm_duty = PW'(duty);
        e.led_a = on_a && (pwm_val < duty);
        e.led_b = on_b && (pwm_val < duty);
        pwm_val = rst ? 0 : (pwm_val + 1) % (1 << PW);
`else
        e.led_a = on_a;
        e.led_b = on_b;
`endif
        if (rst) begin
            e.led_a = 1'b0;
            e.led_b = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Hold code for nticks beat edges spaced `period` clocks apart.
    task automatic run(input int code, input int period, input int nticks);
        for (int t = 0; t < nticks; t++) begin
            for (int c = 1; c < period; c++) cycle(beat_lvl, code, 1'b0);
            beat_lvl = ~beat_lvl;
            cycle(beat_lvl, code, 1'b0);
        end
    endtask

    task automatic do_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            beat_lvl = ~beat_lvl;
            cycle(beat_lvl, 3, 1'b1);
        end
    endtask

    task automatic check(input string name, input bit got, input bit exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0b expected %0b at %0t", name, got, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("led_a",  if_a.led,      e.led_a);
                check("busy_a", if_a.busy,     e.busy_a);
                check("done_a", if_a.seq_done, e.done_a);
                check("led_b",  if_b.led,      e.led_b);
                check("busy_b", if_b.busy,     e.busy_b);
                check("done_b", if_b.seq_done, e.done_b);
            end
        end
    end

    initial begin : stimulus
        int code;
        beat_lvl  = 1'b0;
        beat_prev = 1'b0;
        ma = '{active: 1'b0, n: 0, k: 0};
        mb = '{active: 1'b0, n: 0, k: 0};

        do_reset(3);
        run(3, 10, 24);

        do_reset(2);
        for (int i = 0; i < 200; i++) begin
            if (i % 10 == 9) beat_lvl = ~beat_lvl;
            cycle(beat_lvl, 0, 1'b0);
        end

        // Code change after the first blink only takes effect at the next sequence.
        do_reset(2);
        run(2, 3, 2);
        run(5, 3, 30);

        // Reset during the second ON of code 3, then hold the beat still.
        do_reset(2);
        run(3, 4, 3);
        cycle(beat_lvl, 3, 1'b0);
        cycle(beat_lvl, 3, 1'b1);
        for (int i = 0; i < 10; i++) cycle(beat_lvl, 3, 1'b0);
        run(3, 4, 4);

        run(15, 2, 40);

        // Stuck beat: nothing may move.
        for (int i = 0; i < 60; i++) cycle(beat_lvl, 7, 1'b0);
        run(1, 5, 12);

`ifdef HEART_BEAT_BLINK_PWM_EN
        duty = 8;
        run(1, 40, 8);
        duty = 0;
        run(1, 40, 6);
        duty = 15;
`endif

        code = 5;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0)   code = $urandom_range(0, (1 << CW) - 1);
            if ($urandom_range(0, 2) == 0)     beat_lvl = ~beat_lvl;
`ifdef HEART_BEAT_BLINK_PWM_EN
            if ($urandom_range(0, 299) == 0)   duty = $urandom_range(0, (1 << PW) - 1);
`endif
            cycle(beat_lvl, code, ($urandom_range(0, 799) == 0));
        end

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
